// File: rtl/zuc_stream_gen.sv
// ZUC-128 keystream generator: key/IV config handshake, init/warm-up phases, then one 32-bit
// keystream word per accepted valid/ready beat, with word count, last flag and abort.
module zuc_stream_gen #(
  parameter int unsigned INIT_ROUNDS = 32,
  parameter int unsigned LEN_W       = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [127:0]     key,
  input  logic [127:0]     iv,
  input  logic [LEN_W-1:0] num_words,
  input  logic             abort,
  output logic             z_valid,
  input  logic             z_ready,
  output logic [31:0]      z_data,
  output logic             z_last,
  output logic             busy,
  output logic             done
);

  localparam int unsigned RW = $clog2(INIT_ROUNDS + 1);

  // Row 0 is the most significant 128 bits, so S[x] sits at bit offset 8*(255-x).
  localparam logic [2047:0] S0_TAB = {
    128'h3e725b47cae0003304d1549809b96dcb,
    128'h7b1bf932af9d6aa5b82dfc1d08530390,
    128'h4d4e8499e4ced991ddb685488b296eac,
    128'hcdc1f81e734369c6b5bdfd396320d438,
    128'h767db2a7cfed57c5f32cbb142106559b,
    128'he3ef5e314f7f5aa40d8251495fba581c,
    128'h4a16d517a892241f8cffd8ae2e01d3ad,
    128'h3b4bda46ebc9de9a8f87d73a806f2fc8,
    128'hb1b437f70a2213287ccc3c89c7c39656,
    128'h07bf7ef00b2b975235417961a64c10fe,
    128'hbc2695888ab0a3fbc01894f2e1e5e95d,
    128'hd0dc1166645cec59427512f5749caa23,
    128'h0e86abbe2a02e767e644a26cc2939ff1,
    128'hf6fa36d250689e6271153dd640c4e20f,
    128'h8e83776b25053f0c30ea70b7a1e8a965,
    128'h8d271adb81b3a0f4457a19dfee783460
  };

  localparam logic [2047:0] S1_TAB = {
    128'h55c263713bc847869f3cda5b29aafd77,
    128'h8cc5940ca61a1300e3a8167240f9f842,
    128'h4426689681d9453e1076c6a78b3943e1,
    128'h3ab5562ac06db3052266bfdc0bfa6248,
    128'hdd20110636c9c1cff62752bb69f5d487,
    128'h7f844cd29c57a4bc4f9adffed68d7aeb,
    128'h2b53d85ca11417fb23d57d3067730809,
    128'heeb7703f61b2198e4ee54b938f5ddba9,
    128'hadf1ae2ecb0dfcf42d466e1d97e8d1e9,
    128'h4d37a5755e839eab829db91ce0cd4989,
    128'h01b6bd5824a25f387899159050b895e4,
    128'hd091c7ceed0fb46fa0ccf0024a79c3de,
    128'ha3efea51e66b18ec1b2c80f774e7ff21,
    128'h5a6a541e41319235c433070aba7e0e34,
    128'h88b1987cf33d606c7bcad31f32650428,
    128'h64be859b2f598ad7b025acaf1203e2f2
  };

  // Element i holds d_i.
  localparam logic [15:0][14:0] D_TAB = {
    15'h47AC, 15'h789A, 15'h3C4D, 15'h5E26, 15'h1AF1, 15'h6BC4, 15'h2F13, 15'h4D78,
    15'h09AF, 15'h7135, 15'h35E2, 15'h5789, 15'h135E, 15'h626B, 15'h26BC, 15'h44D7
  };

  function automatic logic [7:0] sb0(input logic [7:0] x);
    logic [10:0] idx;
    idx = {~x, 3'b000};
    return S0_TAB[idx +: 8];
  endfunction

  function automatic logic [7:0] sb1(input logic [7:0] x);
    logic [10:0] idx;
    idx = {~x, 3'b000};
    return S1_TAB[idx +: 8];
  endfunction

  function automatic logic [31:0] sbox32(input logic [31:0] x);
    return {sb0(x[31:24]), sb1(x[23:16]), sb0(x[15:8]), sb1(x[7:0])};
  endfunction

  function automatic logic [31:0] rol32(input logic [31:0] x, input int unsigned k);
    return (x << k) | (x >> (32 - k));
  endfunction

  function automatic logic [31:0] lin1(input logic [31:0] x);
    return x ^ rol32(x, 2) ^ rol32(x, 10) ^ rol32(x, 18) ^ rol32(x, 24);
  endfunction

  function automatic logic [31:0] lin2(input logic [31:0] x);
    return x ^ rol32(x, 8) ^ rol32(x, 14) ^ rol32(x, 22) ^ rol32(x, 30);
  endfunction

  // Multiplication by 2^k modulo 2^31-1 is a 31-bit rotate.
  function automatic logic [30:0] rot31(input logic [30:0] x, input int unsigned k);
    return (x << k) | (x >> (31 - k));
  endfunction

  function automatic logic [30:0] addm(input logic [30:0] a, input logic [30:0] b);
    logic [31:0] t;
    t = {1'b0, a} + {1'b0, b};
    return t[30:0] + {30'd0, t[31]};
  endfunction

  typedef enum logic [2:0] {StIdle, StInit, StWarm, StGen, StDone} state_e;

  state_e            state_q, state_d;
  logic [15:0][30:0] s_q, s_d;
  logic [31:0]       r1_q, r1_d, r2_q, r2_d;
  logic [RW-1:0]     round_q, round_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d, num_q, num_d;

  logic [15:0][7:0]  key_b, iv_b;
  logic [31:0]       x0, x1, x2, x3, w, w1, w2, r1_f, r2_f;
  logic [30:0]       v, s16_init_raw, s16_init, s16_work;

  assign key_b = key;
  assign iv_b  = iv;

  // Bit reorganisation and nonlinear function F on the current state.
  assign x0 = {s_q[15][30:15], s_q[14][15:0]};
  assign x1 = {s_q[11][15:0], s_q[9][30:15]};
  assign x2 = {s_q[7][15:0], s_q[5][30:15]};
  assign x3 = {s_q[2][15:0], s_q[0][30:15]};

  assign w    = (x0 ^ r1_q) + r2_q;
  assign w1   = r1_q + x1;
  assign w2   = r2_q ^ x2;
  assign r1_f = sbox32(lin1({w1[15:0], w2[31:16]}));
  assign r2_f = sbox32(lin2({w2[15:0], w1[31:16]}));

  assign v = addm(addm(addm(addm(addm(s_q[0], rot31(s_q[0], 8)), rot31(s_q[4], 20)),
                            rot31(s_q[10], 21)), rot31(s_q[13], 17)), rot31(s_q[15], 15));

  assign s16_init_raw = addm(v, w[31:1]);
  assign s16_init     = (s16_init_raw == '0) ? '1 : s16_init_raw;
  assign s16_work     = (v == '0) ? '1 : v;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    round_d = round_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    case (state_q)
      StIdle: begin
        if (cfg_valid) begin
          for (int unsigned i = 0; i < 16; i++) begin
            s_d[i] = {key_b[15-i], D_TAB[i], iv_b[15-i]};
          end
          r1_d    = '0;
          r2_d    = '0;
          num_d   = num_words;
          round_d = '0;
          cnt_d   = '0;
          state_d = StInit;
        end
      end
      StInit: begin
        r1_d    = r1_f;
        r2_d    = r2_f;
        s_d     = {s16_init, s_q[15:1]};
        round_d = round_q + RW'(1);
        if (round_q == RW'(INIT_ROUNDS - 1)) state_d = StWarm;
      end
      StWarm: begin
        r1_d    = r1_f;
        r2_d    = r2_f;
        s_d     = {s16_work, s_q[15:1]};
        state_d = (num_q == '0) ? StDone : StGen;
      end
      StGen: begin
        if (z_ready) begin
          r1_d  = r1_f;
          r2_d  = r2_f;
          s_d   = {s16_work, s_q[15:1]};
          cnt_d = cnt_q + LEN_W'(1);
          if (z_last) state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Abort overrides everything, including a final handshake; DONE is already completing.
    if (abort && (state_q inside {StInit, StWarm, StGen})) begin
      state_d = StIdle;
      s_d     = '0;
      r1_d    = '0;
      r2_d    = '0;
      round_d = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      s_q     <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      round_q <= '0;
      cnt_q   <= '0;
      num_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      round_q <= round_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
    end
  end

  assign cfg_ready = (state_q == StIdle);
  assign z_valid   = (state_q == StGen);
  assign busy      = (state_q inside {StInit, StWarm, StGen});
  assign done      = (state_q == StDone);
  assign z_last    = z_valid && (cnt_q == num_q - LEN_W'(1));
  assign z_data    = z_valid ? (w ^ x3) : '0;

endmodule
